// File: rtl/pipe_sum_tree_pkg.sv
// Shared definitions for the pipelined reduction adder.
//   WordLenDefault : default lane / output width of the mat_mul datapath
//   clog2          : ceiling log2, used to size the adder tree
//   lane_lsb       : bit offset of a lane inside a packed lane bus
package pipe_sum_tree_pkg;

  localparam int unsigned WordLenDefault = 32;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pipe_sum_tree_add_stage.sv
// One level of the registered adder tree.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid, in_last  : beat qualifiers, delayed one cycle to out_valid/out_last
//   in_data            : 2*N_PAIRS signed lanes of IN_W bits
//   out_data           : N_PAIRS signed pairwise sums of IN_W+1 bits (no bits lost)
module pipe_add_stage
  import pipe_sum_tree_pkg::*;
#(
  parameter int unsigned IN_W    = 32,
  parameter int unsigned N_PAIRS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [2*N_PAIRS*IN_W-1:0]    in_data,
  output logic                         out_valid,
  output logic                         out_last,
  output logic [N_PAIRS*(IN_W+1)-1:0]  out_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out_last  <= in_last;
    end
  end

  for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;
    logic [IN_W:0]   sum_q;

    assign a = in_data[lane_lsb(2 * p, IN_W) +: IN_W];
    assign b = in_data[lane_lsb(2 * p + 1, IN_W) +: IN_W];

    // Data is not gated by valid; only the qualifier pipe carries meaning.
    always_ff @(posedge clk) begin
      sum_q <= {a[IN_W-1], a} + {b[IN_W-1], b};
    end

    assign out_data[p*(IN_W+1) +: IN_W+1] = sum_q;
  end

endmodule

// File: rtl/pipe_sum_tree.sv
// Pipelined reduction adder: registered binary adder tree over NUM_IN signed lanes,
// optional multi-beat accumulation, arithmetic right-shift scaling and optional saturation.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : beat present this cycle
//   in_last    : final beat of a group (ignored when ACC_EN=0)
//   in_data    : NUM_IN signed lanes, lane k at [k*WORD_LEN +: WORD_LEN]
//   out_valid  : one-cycle result pulse, LEVELS+2 cycles after the last beat
//   out_data   : scaled, saturated or wrapped result; holds until the next result
//   out_sat    : result was clamped (always 0 when SAT_EN=0)
module pipe_sum_tree
  import pipe_sum_tree_pkg::*;
#(
  parameter int unsigned WORD_LEN  = WordLenDefault,
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned SHIFT     = 2,
  parameter bit          SAT_EN    = 1'b1,
  parameter bit          ACC_EN    = 1'b0,
  parameter int unsigned ACC_GUARD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [NUM_IN*WORD_LEN-1:0] in_data,
  output logic                       out_valid,
  output logic [WORD_LEN-1:0]        out_data,
  output logic                       out_sat
);

  localparam int unsigned LEVELS = clog2(NUM_IN);
  localparam int unsigned TREE_W = WORD_LEN + LEVELS;
  localparam int unsigned ACC_W  = TREE_W + ACC_GUARD;

  // Adder tree: level l consumes the previous level's sums.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned IW = WORD_LEN + l;
    localparam int unsigned NP = NUM_IN >> (l + 1);

    logic                   vin;
    logic                   lin;
    logic [2*NP*IW-1:0]     din;
    logic                   v;
    logic                   la;
    logic [NP*(IW+1)-1:0]   sum;

    if (l == 0) begin : g_first
      assign vin = in_valid;
      // Without accumulation every beat closes its own group.
      assign lin = ACC_EN ? in_last : 1'b1;
      assign din = in_data;
    end else begin : g_next
      assign vin = g_lvl[l-1].v;
      assign lin = g_lvl[l-1].la;
      assign din = g_lvl[l-1].sum;
    end

    pipe_add_stage #(
      .IN_W    (IW),
      .N_PAIRS (NP)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vin),
      .in_last   (lin),
      .in_data   (din),
      .out_valid (v),
      .out_last  (la),
      .out_data  (sum)
    );
  end

  logic              tree_valid;
  logic              tree_last;
  logic [TREE_W-1:0] tree_sum;
  logic [ACC_W-1:0]  tree_ext;

  assign tree_valid = g_lvl[LEVELS-1].v;
  assign tree_last  = g_lvl[LEVELS-1].la;
  assign tree_sum   = g_lvl[LEVELS-1].sum;
  assign tree_ext   = {{ACC_GUARD{tree_sum[TREE_W-1]}}, tree_sum};

  // Accumulator stage.
  logic [ACC_W-1:0] acc_q;
  logic             first_q;
  logic             acc_valid_q;
  logic             acc_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      acc_valid_q <= 1'b0;
      acc_last_q  <= 1'b0;
    end else begin
      acc_valid_q <= tree_valid;
      acc_last_q  <= tree_last;
      if (tree_valid) begin
        acc_q   <= first_q ? tree_ext : acc_q + tree_ext;
        first_q <= tree_last;
      end
    end
  end

  // Scale and saturate.
  logic signed [ACC_W-1:0]    scaled;
  logic [ACC_W-WORD_LEN:0]    upper;
  logic                       in_range;
  logic [WORD_LEN-1:0]        data_d;
  logic                       sat_d;
  logic                       fire;

  assign scaled   = $signed(acc_q) >>> SHIFT;
  assign upper    = scaled[ACC_W-1:WORD_LEN-1];
  // Fits in WORD_LEN iff all bits from the result sign bit upward agree.
  assign in_range = (&upper) | ~(|upper);
  assign fire     = acc_valid_q & acc_last_q;

  always_comb begin
    data_d = scaled[WORD_LEN-1:0];
    sat_d  = 1'b0;
    if (SAT_EN && !in_range) begin
      sat_d  = 1'b1;
      data_d = scaled[ACC_W-1] ? {1'b1, {(WORD_LEN-1){1'b0}}} : {1'b0, {(WORD_LEN-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= fire;
      if (fire) begin
        out_data <= data_d;
        out_sat  <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_pipe_sum_tree.sv
// Scoreboard bench: several pipe_sum_tree configurations share one stimulus stream.
// Each configuration has an arithmetic reference model that queues expected results
// (value, saturation flag, arrival time) and a monitor that checks every out_valid.
module tb_pipe_sum_tree;

  localparam int NCFG = 5;
  localparam int W    = 32;
  localparam int NL   = 4;
  localparam int LAT  = 4;
  localparam int PER  = 10;

  localparam int unsigned SH_T  [NCFG] = '{2, 0, 0, 0, 3};
  localparam bit          SAT_T [NCFG] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit          ACC_T [NCFG] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  typedef struct {
    logic [W-1:0] data;
    bit           sat;
    longint       t;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_last;
  logic [NL*W-1:0] in_data;

  logic           o_valid [NCFG];
  logic [W-1:0]   o_data  [NCFG];
  logic           o_sat   [NCFG];

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  always #(PER / 2) clk = ~clk;

  for (genvar i = 0; i < NCFG; i++) begin : g_cfg
    exp_t   q[$];
    longint acc;
    bit     first;

    pipe_sum_tree #(
      .WORD_LEN  (W),
      .NUM_IN    (NL),
      .SHIFT     (SH_T[i]),
      .SAT_EN    (SAT_T[i]),
      .ACC_EN    (ACC_T[i]),
      .ACC_GUARD (8)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_data   (in_data),
      .out_valid (o_valid[i]),
      .out_data  (o_data[i]),
      .out_sat   (o_sat[i])
    );

    // Reference model: exact integer sum of the group, then floor shift and clamp/wrap.
    initial begin
      longint s;
      longint sc;
      exp_t   e;
      acc   = 0;
      first = 1'b1;
      forever begin
        @(posedge clk);
        if (rst) begin
          acc   = 0;
          first = 1'b1;
          q.delete();
        end else if (in_valid) begin
          s = 0;
          for (int k = 0; k < NL; k++) s += longint'($signed(in_data[k*W +: W]));
          acc = first ? s : acc + s;
          if (!ACC_T[i] || in_last) begin
            sc    = acc >>> SH_T[i];
            e.sat = 1'b0;
            if (SAT_T[i]) begin
              if (sc > 64'sd2147483647) begin
                sc    = 64'sd2147483647;
                e.sat = 1'b1;
              end else if (sc < -64'sd2147483648) begin
                sc    = -64'sd2147483648;
                e.sat = 1'b1;
              end
            end
            e.data = sc[W-1:0];
            e.t    = longint'($time) + LAT * PER - PER / 2;
            q.push_back(e);
            first = 1'b1;
          end else begin
            first = 1'b0;
          end
        end
      end
    end

    // Monitor.
    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (o_valid[i] === 1'b1) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL cfg%0d unexpected_out: got data %h, want no output", i, o_data[i]);
          end else begin
            e = q.pop_front();
            checks++;
            if (o_data[i] !== e.data) begin
              errors++;
              $display("FAIL cfg%0d data: got %h want %h", i, o_data[i], e.data);
            end
            checks++;
            if (o_sat[i] !== e.sat) begin
              errors++;
              $display("FAIL cfg%0d sat: got %b want %b", i, o_sat[i], e.sat);
            end
            checks++;
            if (longint'($time) != e.t) begin
              errors++;
              $display("FAIL cfg%0d latency: got t=%0d want t=%0d", i, $time, e.t);
            end
          end
        end
      end
    end

    initial begin
      wait (done);
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL cfg%0d missing_out: got %0d results outstanding, want 0", i, q.size());
      end
    end
  end

  task automatic beat(input logic [W-1:0] l0, input logic [W-1:0] l1, input logic [W-1:0] l2,
                      input logic [W-1:0] l3, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = last;
    in_data  = {l3, l2, l1, l0};
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < NCFG; i++) begin
      checks++;
      if (o_valid[i] !== 1'b0 || o_data[i] !== '0 || o_sat[i] !== 1'b0) begin
        errors++;
        $display("FAIL cfg%0d reset_state: got v=%b d=%h s=%b want 0/0/0", i, o_valid[i],
                 o_data[i], o_sat[i]);
      end
    end
  endtask

  function automatic logic [W-1:0] pick_lane();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h7FFF_FFFF;
      1:       v = 32'h8000_0000;
      2:       v = W'($urandom_range(0, 15));
      3:       v = -W'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int grp;
    int r;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    do_reset(3);
    check_reset_state();

    // Basic sum and floor shift.
    beat(32'd4, 32'd8, 32'd12, 32'd16, 1'b1);
    bubble(6);
    beat(-32'sd1, -32'sd1, -32'sd1, -32'sd2, 1'b1);
    beat(32'd1, 32'd1, 32'd1, 32'd0, 1'b1);
    // Saturation extremes.
    beat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    beat(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1);
    bubble(6);
    // Accumulation with a bubble inside the group.
    beat(32'd1, 32'd1, 32'd1, 32'd1, 1'b0);
    bubble(1);
    beat(32'd1, 32'd1, 32'd1, 32'd1, 1'b0);
    beat(32'd1, 32'd1, 32'd1, 32'd1, 1'b1);
    bubble(6);
    // Back-to-back two-beat groups.
    for (int k = 1; k <= 4; k++) begin
      beat(W'(k), W'(k), W'(k), W'(k), 1'b0);
      beat(W'(k), W'(k), W'(k), W'(k), 1'b1);
    end
    bubble(8);
    // Reset mid-group discards the partial group.
    beat(32'd5, 32'd5, 32'd5, 32'd5, 1'b0);
    beat(32'd5, 32'd5, 32'd5, 32'd5, 1'b0);
    do_reset(1);
    check_reset_state();
    beat(32'd1, 32'd1, 32'd1, 32'd1, 1'b1);
    bubble(8);

    // Randomised traffic.
    grp = 0;
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset(1);
        check_reset_state();
        grp = 0;
      end else if (r < 20) begin
        bubble(int'($urandom_range(1, 3)));
      end else begin
        logic last;
        last = ($urandom_range(0, 2) == 0) || (grp >= 100);
        beat(pick_lane(), pick_lane(), pick_lane(), pick_lane(), last);
        grp = last ? 0 : grp + 1;
      end
    end
    bubble(12);
    done = 1'b1;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
